// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 encodings, FSM state type and small decode helpers.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide iteration: shift {rem,quo} left by one
// and subtract the divisor when it fits, setting the new quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The extra top bit keeps the trial subtraction exact; its sign says whether it fits.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer for the EX stage: latches operands on start,
// runs a multi-cycle multiply or a radix-2 restoring divide, stalls the pipe meanwhile.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_validE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] srcAE,
    input  logic [XLEN-1:0] srcBE,
    input  logic            kill,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] resultE
);

    localparam int CNT_W = $clog2(XLEN + 1);

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN:0]     opA_q, opA_d;
    logic [XLEN:0]     opB_q, opB_d;
    logic              negQ_q, negQ_d;
    logic              negR_q, negR_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]         stepRem, stepQuo;
    logic signed [2*XLEN+1:0] prodFull;
    logic [2*XLEN-1:0]       prodSel;
    logic                    aNeg, bNeg, sgnDiv;
    logic [XLEN-1:0]         absA, absB;
    logic                    divZero, divOvf;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(opB_q[XLEN-1:0]),
        .rem_o    (stepRem),
        .quo_o    (stepQuo)
    );

    // Operands are held in XLEN+1 bits so one signed multiply covers all four MUL variants.
    assign prodFull = $signed(opA_q) * $signed(opB_q);
    assign prodSel  = (cnt_q == CNT_W'(MUL_LAT)) ? prodFull[2*XLEN-1:0] : prod_q;

    assign sgnDiv  = ~funct3E[0];
    assign aNeg    = srcAE[XLEN-1];
    assign bNeg    = srcBE[XLEN-1];
    assign absA    = (sgnDiv && aNeg) ? -srcAE : srcAE;
    assign absB    = (sgnDiv && bNeg) ? -srcBE : srcBE;
    assign divZero = (srcBE == '0);
    assign divOvf  = sgnDiv && (srcAE == {1'b1, {(XLEN-1){1'b0}}}) && (srcBE == '1);

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign resultE = result_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        negQ_d    = negQ_q;
        negR_d    = negR_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        prod_d    = prod_q;
        result_d  = result_q;
        stall_req = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (op_validE && !kill) begin
                    stall_req = 1'b1;
                    funct3_d  = funct3E;
                    if (is_div(funct3E)) begin
                        opA_d  = {1'b0, absA};
                        opB_d  = {1'b0, absB};
                        negQ_d = sgnDiv && (aNeg ^ bNeg);
                        negR_d = sgnDiv && aNeg;
                        rem_d  = '0;
                        quo_d  = absA;
                        if (divZero) begin
                            state_d  = DONE;
                            cnt_d    = '0;
                            result_d = funct3E[1] ? srcAE : '1;
                        end else if (divOvf) begin
                            state_d  = DONE;
                            cnt_d    = '0;
                            result_d = funct3E[1] ? '0 : srcAE;
                        end else begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(XLEN);
                        end
                    end else begin
                        opA_d   = {(funct3E == MD_MULH || funct3E == MD_MULHSU) && aNeg, srcAE};
                        opB_d   = {(funct3E == MD_MULH) && bNeg, srcBE};
                        state_d = RUN;
                        cnt_d   = CNT_W'(MUL_LAT);
                    end
                end
            end
            RUN: begin
                stall_req = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (is_div(funct3_q)) begin
                    rem_d = stepRem;
                    quo_d = stepQuo;
                end else begin
                    prod_d = prodSel;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (is_div(funct3_q)) begin
                        if (funct3_q[1]) result_d = negR_q ? -stepRem : stepRem;
                        else             result_d = negQ_q ? -stepQuo : stepQuo;
                    end else if (funct3_q == MD_MUL) begin
                        result_d = prodSel[XLEN-1:0];
                    end else begin
                        result_d = prodSel[2*XLEN-1:XLEN];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush abandons whatever was in flight and leaves the last result visible.
        if (kill) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, fast paths,
// kill and mid-operation reset, all against hand-computed values.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        op_validE;
    logic [2:0]  funct3E;
    logic [31:0] srcAE;
    logic [31:0] srcBE;
    logic        kill;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] resultE;

    int errors = 0;
    int checks = 0;

    muldiv_seq #(.XLEN(32), .MUL_LAT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_validE(op_validE),
        .funct3E  (funct3E),
        .srcAE    (srcAE),
        .srcBE    (srcBE),
        .kill     (kill),
        .stall_req(stall_req),
        .busy     (busy),
        .done     (done),
        .resultE  (resultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op from IDLE (called 1ns after a rising edge) and reports what it saw.
    task automatic doOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic stall0,
                        output int stallGaps, output logic doneStall);
        funct3E   = f3;
        srcAE     = a;
        srcBE     = b;
        op_validE = 1'b1;
        #1;
        stall0 = stall_req;
        @(posedge clk); #1;
        op_validE = 1'b0;
        lat       = -1;
        res       = 32'hDEAD_BEEF;
        stallGaps = 0;
        doneStall = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat       = c;
                res       = resultE;
                doneStall = stall_req;
                break;
            end
            if (!stall_req) stallGaps++;
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_validE = 1'b0; kill = 1'b0;
        funct3E = 3'd0; srcAE = '0; srcBE = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, stall_req, resultE} !== 35'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b stall=%b result=%h expected all zero",
                     busy, done, stall_req, resultE);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat, gaps; logic [31:0] res; logic s0, ds;
        doOp(3'd0, 32'd7, 32'hFFFF_FFFD, lat, res, s0, gaps, ds);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 3", lat); end
        checks++;
        if (res !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", res); end
        checks++;
        if ({s0, gaps != 0, ds} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL mul_stall: cycle0=%b gaps=%0d in_done=%b expected 1/0/0", s0, gaps, ds);
        end
    endtask

    task automatic test_mulh();
        int lat, gaps; logic [31:0] res; logic s0, ds;
        doOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'hFFFF_FFFE || lat !== 3) begin
            errors++; $display("[TB] FAIL mulhu: got %h lat %0d expected fffffffe lat 3", res, lat);
        end
        doOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'h0000_0000 || lat !== 3) begin
            errors++; $display("[TB] FAIL mulh: got %h lat %0d expected 00000000 lat 3", res, lat);
        end
        doOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL mulhsu: got %h expected ffffffff", res);
        end
    endtask

    task automatic test_div();
        int lat, gaps; logic [31:0] res; logic s0, ds;
        doOp(3'd4, 32'hFFFF_FFF9, 32'd2, lat, res, s0, gaps, ds);
        checks++;
        if (lat !== 33) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 33", lat); end
        checks++;
        if (res !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_neg: got %h expected fffffffd", res); end
        checks++;
        if ({s0, gaps != 0, ds} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL div_stall: cycle0=%b gaps=%0d in_done=%b expected 1/0/0", s0, gaps, ds);
        end
        doOp(3'd6, 32'hFFFF_FFF9, 32'd2, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rem_neg: got %h expected ffffffff", res); end
        doOp(3'd7, 32'd100, 32'd7, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'd2) begin errors++; $display("[TB] FAIL remu: got %h expected 00000002", res); end
        doOp(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'd0 || lat !== 33) begin
            errors++; $display("[TB] FAIL divu_big: got %h lat %0d expected 00000000 lat 33", res, lat);
        end
    endtask

    task automatic test_div_fast();
        int lat, gaps; logic [31:0] res; logic s0, ds;
        doOp(3'd4, 32'd5, 32'd0, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 1) begin
            errors++; $display("[TB] FAIL div_by_zero: got %h lat %0d expected ffffffff lat 1", res, lat);
        end
        doOp(3'd7, 32'd5, 32'd0, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'd5 || lat !== 1) begin
            errors++; $display("[TB] FAIL remu_by_zero: got %h lat %0d expected 00000005 lat 1", res, lat);
        end
        doOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'h8000_0000 || lat !== 1) begin
            errors++; $display("[TB] FAIL div_overflow: got %h lat %0d expected 80000000 lat 1", res, lat);
        end
        doOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'd0 || lat !== 1) begin
            errors++; $display("[TB] FAIL rem_overflow: got %h lat %0d expected 00000000 lat 1", res, lat);
        end
    endtask

    task automatic test_kill();
        int lat, gaps, doneSeen; logic [31:0] res; logic s0, ds;
        doOp(3'd5, 32'd100, 32'd7, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'd14) begin errors++; $display("[TB] FAIL divu: got %h expected 0000000e", res); end
        funct3E = 3'd4; srcAE = 32'd1000; srcBE = 32'd3; op_validE = 1'b1;
        @(posedge clk); #1;
        op_validE = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00 || resultE !== 32'd14) begin
            errors++;
            $display("[TB] FAIL kill_abort: busy=%b done=%b result=%h expected 0/0/0000000e", busy, done, resultE);
        end
        doneSeen = 0;
        repeat (40) begin
            if (done) doneSeen++;
            @(posedge clk); #1;
        end
        checks++;
        if (doneSeen !== 0) begin errors++; $display("[TB] FAIL kill_no_done: saw %0d done cycles expected 0", doneSeen); end
        funct3E = 3'd0; srcAE = 32'd2; srcBE = 32'd2; op_validE = 1'b1; kill = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL kill_start_stall: got %b expected 0", stall_req); end
        @(posedge clk); #1;
        op_validE = 1'b0; kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || resultE !== 32'd14) begin
            errors++; $display("[TB] FAIL kill_start_nostart: busy=%b result=%h expected 0/0000000e", busy, resultE);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, gaps; logic [31:0] res; logic s0, ds;
        funct3E = 3'd4; srcAE = 32'd1000; srcBE = 32'd3; op_validE = 1'b1;
        @(posedge clk); #1;
        op_validE = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, stall_req, resultE} !== 35'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_op: busy=%b done=%b stall=%b result=%h expected all zero",
                     busy, done, stall_req, resultE);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        doOp(3'd0, 32'd3, 32'd4, lat, res, s0, gaps, ds);
        checks++;
        if (res !== 32'd12 || lat !== 3) begin
            errors++; $display("[TB] FAIL mul_after_reset: got %h lat %0d expected 0000000c lat 3", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_fast();
        test_kill();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
